oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 91 +++++++++
 tb/tb_oam_dma.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: halts the CPU and copies one 256-byte page into OAM.
// State advances on falling edges of i_clk qualified by i_ce.
module oam_dma (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic        i_dma_wr,
  input  logic [7:0]  i_dma_page,
  input  logic [7:0]  i_oamaddr,
  input  logic [7:0]  i_bus_data,
  output logic [15:0] o_bus_address,
  output logic        o_bus_rw_n,
  output logic        o_cpu_rdy,
  output logic        o_oam_wr,
  output logic [7:0]  o_oam_address,
  output logic [7:0]  o_oam_data,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0] state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] page_q, page_d;
  logic [7:0] base_q, base_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    state_d  = state_q;
    parity_d = ~parity_q;
    page_d   = page_q;
    base_d   = base_q;
    index_d  = index_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_dma_wr) begin
          state_d = S_HALT;
          page_d  = i_dma_page;
          base_d  = i_oamaddr;
          index_d = 8'd0;
        end
      end
      // Reads must land on get cycles: the cycle after HALT has parity ~parity_q.
      S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        data_d  = i_bus_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + 8'd1;
        state_d = (index_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'd0;
      base_q   <= 8'd0;
      index_q  <= 8'd0;
      data_q   <= 8'd0;
    end else if (i_ce) begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      base_q   <= base_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end

  // Outputs decode registered state only; nothing flows from inputs.
  assign o_bus_address = (state_q == S_READ)  ? {page_q, index_q} : 16'd0;
  assign o_bus_rw_n    = 1'b1;
  assign o_oam_wr      = (state_q == S_WRITE);
  assign o_oam_address = (state_q == S_WRITE) ? (base_q + index_q) : 8'd0;
  assign o_oam_data    = (state_q == S_WRITE) ? data_q : 8'd0;
  assign o_cpu_rdy     = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: scoreboard of expected OAM writes per transfer.
module tb_oam_dma;
  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ce;
  logic        i_dma_wr;
  logic [7:0]  i_dma_page;
  logic [7:0]  i_oamaddr;
  logic [7:0]  i_bus_data;
  logic [15:0] o_bus_address;
  logic        o_bus_rw_n;
  logic        o_cpu_rdy;
  logic        o_oam_wr;
  logic [7:0]  o_oam_address;
  logic [7:0]  o_oam_data;
  logic        o_busy;

  oam_dma dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_dma_wr(i_dma_wr),
    .i_dma_page(i_dma_page), .i_oamaddr(i_oamaddr), .i_bus_data(i_bus_data),
    .o_bus_address(o_bus_address), .o_bus_rw_n(o_bus_rw_n), .o_cpu_rdy(o_cpu_rdy),
    .o_oam_wr(o_oam_wr), .o_oam_address(o_oam_address), .o_oam_data(o_oam_data),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8];
    return (lo * 8'd3) ^ hi ^ 8'h5A;
  endfunction

  always_comb i_bus_data = mem(o_bus_address);

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;
  int lowcnt, wrcnt, precnt, viol;
  logic [7:0]  exp_page;
  logic [15:0] lastrd;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},   {31'd0, o_cpu_rdy},  1);
    chk({tag, "_busy"},  {31'd0, o_busy},     0);
    chk({tag, "_wr"},    {31'd0, o_oam_wr},   0);
    chk({tag, "_rw"},    {31'd0, o_bus_rw_n}, 1);
    chk({tag, "_baddr"}, {16'd0, o_bus_address}, 0);
    chk({tag, "_oaddr"}, {24'd0, o_oam_address}, 0);
    chk({tag, "_odata"}, {24'd0, o_oam_data},    0);
  endtask

  // Observe the current period; it is a ce-cycle only if ce is driven high for its closing edge.
  task automatic process();
    logic [15:0] e;
    if (!o_cpu_rdy) lowcnt++;
    if (o_busy && !o_oam_wr && o_bus_address == 16'd0) precnt++;
    if (o_bus_address != 16'd0) begin
      lastrd = o_bus_address;
      if (o_bus_address[15:8] != exp_page) viol++;
    end
    if (o_oam_wr) begin
      wrcnt++;
      if (sb.size() == 0) chk("sb_extra_write", {16'd0, o_oam_address, o_oam_data}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("oam_write", {16'd0, o_oam_address, o_oam_data}, {16'd0, e});
      end
    end
  endtask

  task automatic tick(input logic ce, input logic wr);
    i_ce = ce;
    i_dma_wr = wr;
    if (ce) begin
      process();
      pcnt++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] pg, input logic [7:0] ba, input bit rnd,
                      input int exp_low, input int retrig, input int rst_at);
    int cec;
    bit done;
    logic ce;
    while ((pcnt % 2) != ((exp_low == 513) ? 0 : 1)) tick(1'b1, 1'b0);
    sb.delete();
    for (int n = 0; n < 256; n++) sb.push_back({ba + 8'(n), mem({pg, 8'(n)})});
    lowcnt = 0; wrcnt = 0; precnt = 0; viol = 0; exp_page = pg; lastrd = 16'd0;
    i_dma_page = pg;
    i_oamaddr  = ba;
    tick(1'b1, 1'b1);
    i_dma_page = ~pg;
    i_oamaddr  = ~ba;
    cec = 0;
    done = 0;
    for (int t = 0; t < 4000; t++) begin
      if (!o_busy && cec > 0) begin done = 1; break; end
      if (rst_at >= 0 && cec == rst_at) begin
        #2 i_reset_n = 1'b0;
        #1 chk_reset_outs("midreset");
        pcnt = 0;
        done = 1;
        break;
      end
      ce = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick(ce, ce && (cec == retrig));
      cec += int'(ce);
    end
    if (!done) chk("timeout", 0, 1);
    if (rst_at < 0) begin
      chk("halt_len", lowcnt, exp_low);
      chk("write_cnt", wrcnt, 256);
      chk("sb_left", sb.size(), 0);
      chk("halt_align_cycles", precnt, exp_low - 512);
      chk("page_violations", viol, 0);
      chk("last_read", {16'd0, lastrd}, {16'd0, pg, 8'hFF});
    end
  endtask

  initial begin
    i_reset_n = 1'b0; i_ce = 1'b0; i_dma_wr = 1'b0; i_dma_page = 8'd0; i_oamaddr = 8'd0;
    #3 chk_reset_outs("reset");
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Trigger with ce low must be ignored
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    chk("ce0_wr_ignored", {31'd0, o_busy}, 0);

    xfer(8'h02, 8'h00, 1'b0, 513, -1, -1);
    xfer(8'h02, 8'h00, 1'b0, 514, -1, -1);
    xfer(8'h07, 8'hF0, 1'b0, 513, -1, -1);
    xfer(8'h03, 8'h10, 1'b1, 513, -1, -1);
    xfer(8'h03, 8'h10, 1'b1, 514, -1, -1);
    xfer(8'h04, 8'h00, 1'b0, 514, 100, -1);

    xfer(8'h05, 8'h20, 1'b0, 513, -1, 300);
    sb.delete();
    wrcnt = 0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    chk_reset_outs("held_reset");
    i_reset_n = 1'b1;
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
    chk("post_reset_writes", wrcnt, 0);
    chk("post_reset_busy", {31'd0, o_busy}, 0);
    chk("post_reset_rdy", {31'd0, o_cpu_rdy}, 1);

    xfer(8'h06, 8'h80, 1'b0, 513, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
